// File: rtl/excess3_serial_decoder.sv
// Serial Excess-3 to BCD decoder.
// Takes one Excess-3 digit as four serial bits, LSB first, and subtracts
// the constant 0011 bit-serially with a borrow flip-flop. It produces the
// decoded bit stream, a registered parallel digit, and a flag for the six
// illegal codes. All state updates on the falling clock edge, which matches
// the companion encoder FSM.
module excess3_serial_decoder #(
    parameter int ERR_STICKY = 0
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       X_VALID,
    input  logic       X_START,
    input  logic       X,
    output logic       D,
    output logic       D_VALID,
    output logic [3:0] BCD,
    output logic       BCD_VALID,
    output logic       ERR,
    output logic       BUSY
);

    // Difference bit of a one-bit full subtractor.
    function automatic logic fs_diff(input logic a, input logic s, input logic b);
        return a ^ s ^ b;
    endfunction

    // Borrow-out of a one-bit full subtractor computing a - s - b.
    function automatic logic fs_borrow(input logic a, input logic s, input logic b);
        return (~a & s) | (~a & b) | (s & b);
    endfunction

    // State registers.
    logic [1:0] cnt_r;
    logic       borrow_r;
    logic [3:0] bits_r;
    logic       d_r;
    logic       d_valid_r;
    logic [3:0] bcd_r;
    logic       bcd_valid_r;
    logic       err_r;
    logic       busy_r;

    // Per-bit datapath signals.
    logic [1:0] idx_s;
    logic       sub_s;
    logic       bin_s;
    logic       d_s;
    logic       bnext_s;
    logic [3:0] digit_s;
    logic       illegal_s;

    // Next-state values.
    logic [1:0] cnt_n_s;
    logic       borrow_n_s;
    logic [3:0] bits_n_s;
    logic       d_n_s;
    logic       d_valid_n_s;
    logic [3:0] bcd_n_s;
    logic       bcd_valid_n_s;
    logic       err_n_s;
    logic       busy_n_s;

    // Bit-serial subtraction of 0011: position selection, borrow chain and the legality test.
    always_comb begin
        if (X_START) begin
            idx_s = 2'd0;
        end else begin
            idx_s = cnt_r;
        end
        sub_s     = (idx_s == 2'd0) || (idx_s == 2'd1);
        bin_s     = (idx_s == 2'd0) ? 1'b0 : borrow_r;
        d_s       = fs_diff(X, sub_s, bin_s);
        bnext_s   = fs_borrow(X, sub_s, bin_s);
        digit_s   = {d_s, bits_r[2:0]};
        illegal_s = bnext_s | (digit_s > 4'd9);
    end

    // Next-state logic: accept a bit, complete a digit, or hold through a stall.
    always_comb begin
        cnt_n_s       = cnt_r;
        borrow_n_s    = borrow_r;
        bits_n_s      = bits_r;
        d_n_s         = d_r;
        d_valid_n_s   = 1'b0;
        bcd_n_s       = bcd_r;
        bcd_valid_n_s = 1'b0;
        // A non-sticky error lasts only for the completion cycle.
        if (ERR_STICKY != 0) begin
            err_n_s = err_r;
        end else begin
            err_n_s = 1'b0;
        end
        if (X_VALID) begin
            d_n_s           = d_s;
            d_valid_n_s     = 1'b1;
            bits_n_s[idx_s] = d_s;
            borrow_n_s      = bnext_s;
            cnt_n_s         = idx_s + 2'd1;
            if (idx_s == 2'd3) begin
                bcd_n_s       = digit_s;
                bcd_valid_n_s = 1'b1;
                if (illegal_s) begin
                    err_n_s = 1'b1;
                end else begin
                    err_n_s = (ERR_STICKY != 0) ? err_r : 1'b0;
                end
            end else begin
                bcd_valid_n_s = 1'b0;
            end
        end else begin
            d_valid_n_s = 1'b0;
        end
        busy_n_s = (cnt_n_s != 2'd0);
    end

    // Falling-edge state register with asynchronous active-low reset.
    always_ff @(negedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_r       <= 2'd0;
            borrow_r    <= 1'b0;
            bits_r      <= 4'd0;
            d_r         <= 1'b0;
            d_valid_r   <= 1'b0;
            bcd_r       <= 4'd0;
            bcd_valid_r <= 1'b0;
            err_r       <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            cnt_r       <= cnt_n_s;
            borrow_r    <= borrow_n_s;
            bits_r      <= bits_n_s;
            d_r         <= d_n_s;
            d_valid_r   <= d_valid_n_s;
            bcd_r       <= bcd_n_s;
            bcd_valid_r <= bcd_valid_n_s;
            err_r       <= err_n_s;
            busy_r      <= busy_n_s;
        end
    end

    assign D         = d_r;
    assign D_VALID   = d_valid_r;
    assign BCD       = bcd_r;
    assign BCD_VALID = bcd_valid_r;
    assign ERR       = err_r;
    assign BUSY      = busy_r;

endmodule

// File: doc/excess3_serial_decoder.md
Name: excess3_serial_decoder

Overview:
- Serial Excess-3 to BCD decoder: the receive-side counterpart of the lab's serial binary-to-Excess-3 FSM.
- Accepts one Excess-3 digit as 4 serial bits, LSB first, and subtracts 3 bit-serially with a borrow flip-flop.
- Emits the decoded BCD bit stream and a registered parallel BCD digit.
- Flags the six illegal Excess-3 codes.

Parameters:
ERR_STICKY, 0, 0: ERR is valid for the BCD_VALID cycle only; 1: ERR holds until RST_N is asserted.

Ports:
CLK  input  1  clock; all state updates on the falling edge, matching the encoder FSM
RST_N  input  1  reset, asynchronous, active-low
X_VALID  input  1  X carries a code bit this cycle
X_START  input  1  qualifies X as bit 0 of a new digit (only meaningful with X_VALID)
X  input  1  serial Excess-3 bit, LSB first
D  output  1  decoded BCD bit, registered
D_VALID  output  1  D valid, one cycle per accepted input bit
BCD  output  4  last completed decoded digit
BCD_VALID  output  1  one-cycle pulse when BCD updates
ERR  output  1  completed code was illegal (0000, 0001, 0010, 1101, 1110, 1111)
BUSY  output  1  digit in progress (bit count != 0)

Behaviour:
- Reset (RST_N low, asynchronous): bit counter=0, borrow=0, shift register=0, D=0, D_VALID=0, BCD=0, BCD_VALID=0, ERR=0, BUSY=0.
- Each falling edge with X_VALID=1 accepts one bit.
  - Bit index i = counter, or 0 if X_START=1.
  - Subtrahend s = 1 for i in {0,1}, else 0 (constant 0011).
  - Borrow-in b = 0 when i=0, else the registered borrow.
  - d = X ^ s ^ b; borrow_next = (~X & s) | (~X & b) | (s & b).
  - D <= d, D_VALID <= 1, shift register bit i <= d, counter <= i+1 (mod 4).
- Falling edge with X_VALID=0 is a stall:
  - D_VALID <= 0, BCD_VALID <= 0.
  - Counter, borrow and partial digit hold; no timeout.
- Digit completion (accepted bit with i=3), on that same edge:
  - BCD <= {d, bits[2:0]}, BCD_VALID <= 1, counter <= 0.
  - ERR <= (borrow_next==1) | ({d,bits[2:0]} > 9).
  - When ERR is set, BCD still shows the raw 4-bit difference, mod 16.
- Latency: D is one edge after bit acceptance; BCD/BCD_VALID appear on the edge that accepts bit 3. No backpressure.
- BCD_VALID is a single-cycle pulse, even when the next bit arrives back-to-back.
- BCD holds its value between digits.
- ERR with ERR_STICKY=0:
  - Cleared on any edge where BCD_VALID is not being set.
  - When ERR_STICKY=0, ERR always coincides with BCD_VALID.
- ERR with ERR_STICKY=1: set by any illegal digit; cleared only by reset.
- X_START asserted while BUSY=1:
  - The partial digit is discarded without a BCD_VALID pulse.
  - The current bit is treated as bit 0 of a new digit.
- X_START=1 with X_VALID=0 is ignored.
- BUSY=1 iff counter != 0 after the edge.
- Reset mid-digit discards the partial digit, borrow and outputs immediately; no pulse follows release.
- Back-to-back digits with X_VALID held high produce BCD_VALID every 4th cycle with no idle cycle required.

Test Plan:
- Reset values: hold RST_N=0 for 2 cycles -> all outputs 0. Release and idle 3 cycles -> outputs stay 0, BUSY=0.
- Legal digits: send 0011 as bits 1,1,0,0 -> D=0,0,0,0, BCD=0000, BCD_VALID pulses once, ERR=0.
  - Send 1100 as bits 0,0,1,1 -> D=1,0,0,1, BCD=1001.
  - Send 0111 -> BCD=0100.
  - Run all ten legal codes back-to-back with no gaps -> BCD_VALID every 4th cycle, each BCD = code-3.
- Illegal codes: 0010 -> ERR=1 with BCD_VALID, BCD=1111. 1111 -> ERR=1, BCD=1100.
  - With ERR_STICKY=0, the next legal 0100 -> ERR=0, BCD=0001.
  - With ERR_STICKY=1, ERR stays 1 until reset.
- Stalls: send 1011 (->1000) with X_VALID low for 3 cycles between bits 1 and 2 -> D_VALID low during the stall, BUSY=1, final BCD=1000, exactly one BCD_VALID.
- Resync: send 2 bits of 1010, then X_START with a full 0110 -> no pulse for the partial digit, BCD=0011.
- Async reset: assert RST_N low mid-cycle after bit 2 of 1001 -> outputs clear without waiting for a clock edge.
  - Then send 0101 -> BCD=0010, ERR=0.
